ct_hpcp_event_cnt: RTL and testbench

Per-counter 64-bit hardware performance event counter in the HPCP. It is the stage directly upstream of each counter's overflow-flag register. It accumulates masked per-cycle event counts through a two-stage split-carry adder and accepts committed CSR writes. On wrap-around it emits a single-cycle `counter_overflow_x` pulse, which the downstream flag register ORs into its sticky `cntof_x` bit.

---
 rtl/ct_hpcp_event_cnt.sv | 90 +++++++++
 tb/tb_ct_hpcp_event_cnt.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ct_hpcp_event_cnt.sv
// Per-counter HPCP event counter: masked event accumulation through a split-carry
// two-half adder, committed CSR writes with full pipeline override, one-cycle wrap pulse.
module ct_hpcp_event_cnt #(
  parameter int CNT_WIDTH = 64,
  parameter int INC_WIDTH = 3
) (
  input  logic                 hpcp_clk,
  input  logic                 cpurst_b,
  input  logic                 event_vld_x,
  input  logic [INC_WIDTH-1:0] event_num_x,
  input  logic                 cnt_inhibit_x,
  input  logic                 cnt_mode_en_x,
  input  logic                 cnt_wen_x,
  input  logic                 l2cnt_cmplt_ff,
  input  logic [CNT_WIDTH-1:0] hpcp_wdata_x,
  output logic [CNT_WIDTH-1:0] cnt_value_x,
  output logic                 counter_overflow_x
);

  localparam int HW = CNT_WIDTH / 2;

  logic                 w_wr;
  logic                 w_cnt_en;
  logic [INC_WIDTH-1:0] w_inc_nxt;
  logic [INC_WIDTH-1:0] w_inc_eff;
  logic [HW:0]          w_lo_sum;
  logic                 w_hi_ones;
  logic [HW-1:0]        w_hi_corr;

  logic [INC_WIDTH-1:0] r_inc;
  logic                 r_wr;
  logic [HW-1:0]        r_lo;
  logic [HW-1:0]        r_hi;
  logic                 r_carry;
  logic                 r_ovf;

  assign w_wr     = cnt_wen_x & l2cnt_cmplt_ff;
  assign w_cnt_en = event_vld_x & cnt_mode_en_x & ~cnt_inhibit_x & ~w_wr;

  // Stage-1 mask, and the low-add operand suppressed in the cycle after a write.
  always_comb begin
    w_inc_nxt = {INC_WIDTH{1'b0}};
    w_inc_eff = {INC_WIDTH{1'b0}};
    if (w_cnt_en) begin
      w_inc_nxt = event_num_x;
    end else begin
      w_inc_nxt = {INC_WIDTH{1'b0}};
    end
    if (r_wr) begin
      w_inc_eff = {INC_WIDTH{1'b0}};
    end else begin
      w_inc_eff = r_inc;
    end
  end

  assign w_lo_sum  = {1'b0, r_lo} + {{(HW + 1 - INC_WIDTH){1'b0}}, w_inc_eff};
  assign w_hi_ones = &r_hi;
  assign w_hi_corr = r_hi + {{(HW - 1){1'b0}}, r_carry};

  // Pipeline state: a committed write overrides every stage in the same cycle.
  always_ff @(posedge hpcp_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_inc   <= {INC_WIDTH{1'b0}};
      r_wr    <= 1'b0;
      r_lo    <= {HW{1'b0}};
      r_hi    <= {HW{1'b0}};
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_inc <= w_inc_nxt;
      r_wr  <= w_wr;
      if (w_wr) begin
        r_lo    <= hpcp_wdata_x[HW-1:0];
        r_carry <= 1'b0;
        r_hi    <= hpcp_wdata_x[CNT_WIDTH-1:HW];
        r_ovf   <= 1'b0;
      end else begin
        r_lo    <= w_lo_sum[HW-1:0];
        r_carry <= w_lo_sum[HW];
        r_hi    <= w_hi_corr;
        r_ovf   <= r_carry & w_hi_ones;
      end
    end
  end

  // Reads fold the pending carry in so a half-propagated value is never visible.
  assign cnt_value_x        = {w_hi_corr, r_lo};
  assign counter_overflow_x = r_ovf;

endmodule

// File: tb/tb_ct_hpcp_event_cnt.sv
// Randomized scoreboard bench for ct_hpcp_event_cnt: a cycle-level arithmetic model
// predicts the visible count and wrap pulse; a negedge monitor compares each cycle.
module tb_ct_hpcp_event_cnt;

  logic        hpcp_clk = 1'b0;
  logic        cpurst_b;
  logic        event_vld_x;
  logic [2:0]  event_num_x;
  logic        cnt_inhibit_x;
  logic        cnt_mode_en_x;
  logic        cnt_wen_x;
  logic        l2cnt_cmplt_ff;
  logic [63:0] hpcp_wdata_x;
  logic [63:0] cnt_value_x;
  logic        counter_overflow_x;

  ct_hpcp_event_cnt #(.CNT_WIDTH(64), .INC_WIDTH(3)) dut (
    .hpcp_clk          (hpcp_clk),
    .cpurst_b          (cpurst_b),
    .event_vld_x       (event_vld_x),
    .event_num_x       (event_num_x),
    .cnt_inhibit_x     (cnt_inhibit_x),
    .cnt_mode_en_x     (cnt_mode_en_x),
    .cnt_wen_x         (cnt_wen_x),
    .l2cnt_cmplt_ff    (l2cnt_cmplt_ff),
    .hpcp_wdata_x      (hpcp_wdata_x),
    .cnt_value_x       (cnt_value_x),
    .counter_overflow_x(counter_overflow_x)
  );

  always #5 hpcp_clk = ~hpcp_clk;

  typedef struct packed {
    logic [63:0] val;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   n_ovf  = 0;

  // Model history: architectural value of previous cycles, accepted increments, writes.
  logic [63:0] v1, v2, wd1;
  logic [2:0]  i1, i2, i3;
  logic        w1, w2;

  task automatic clear_model();
    v1 = 64'd0; v2 = 64'd0; wd1 = 64'd0;
    i1 = 3'd0;  i2 = 3'd0;  i3 = 3'd0;
    w1 = 1'b0;  w2 = 1'b0;
  endtask

  task automatic cycle(input bit rst, input bit vld, input logic [2:0] num, input bit inh,
                       input bit mode, input bit wen, input bit cmplt, input logic [63:0] wd);
    exp_t        e;
    logic [64:0] s;
    logic [2:0]  inc_c;
    bit          wr_c;
    @(posedge hpcp_clk);
    #1;
    cyc            = cyc + 1;
    cpurst_b       = !rst;
    event_vld_x    = vld;
    event_num_x    = num;
    cnt_inhibit_x  = inh;
    cnt_mode_en_x  = mode;
    cnt_wen_x      = wen;
    l2cnt_cmplt_ff = cmplt;
    hpcp_wdata_x   = wd;
    e.cyc = cyc;
    if (rst) begin
      e.val = 64'd0;
      e.ovf = 1'b0;
      clear_model();
    end else begin
      // Value = previous value plus the increment accepted two cycles ago, unless a write landed.
      s     = {1'b0, v2} + {62'd0, i3};
      e.val = w1 ? wd1 : v1 + {61'd0, i2};
      e.ovf = !w1 && !w2 && s[64];
      wr_c  = wen && cmplt;
      inc_c = (vld && mode && !inh && !wr_c) ? num : 3'd0;
      v2 = v1; v1 = e.val;
      i3 = i2; i2 = i1; i1 = inc_c;
      w2 = w1; w1 = wr_c; wd1 = wd;
    end
    if (e.ovf) n_ovf = n_ovf + 1;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic evt(input logic [2:0] num);
    cycle(1'b0, 1'b1, num, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic wr(input logic [63:0] d);
    cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, d);
  endtask

  // Monitor: every cycle the DUT presents a value and a pulse; pop and compare.
  always @(negedge hpcp_clk) begin
    exp_t m;
    if (q.size() > 0) begin
      m = q.pop_front();
      checks = checks + 1;
      if (cnt_value_x !== m.val) begin
        errors = errors + 1;
        $display("FAIL value cyc=%0d got=%h exp=%h", m.cyc, cnt_value_x, m.val);
      end
      checks = checks + 1;
      if (counter_overflow_x !== m.ovf) begin
        errors = errors + 1;
        $display("FAIL overflow cyc=%0d got=%b exp=%b", m.cyc, counter_overflow_x, m.ovf);
      end
    end
  end

  initial begin
    logic [63:0] d;
    int          r;
    clear_model();
    cpurst_b = 1'b0; event_vld_x = 1'b0; event_num_x = 3'd0; cnt_inhibit_x = 1'b0;
    cnt_mode_en_x = 1'b1; cnt_wen_x = 1'b0; l2cnt_cmplt_ff = 1'b0; hpcp_wdata_x = 64'd0;
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    idle(2);
    for (int k = 0; k < 4; k++) evt(3'd3);
    idle(4);
    // Low-half carry into the high half.
    wr(64'h0000_0000_FFFF_FFFE); evt(3'd5); idle(5);
    // Full-width wrap.
    wr(64'hFFFF_FFFF_FFFF_FFFD); evt(3'd4); idle(5);
    // Write overrides a wrapping increment in flight.
    wr(64'hFFFF_FFFF_FFFF_FFFF); idle(1); evt(3'd1); wr(64'h10); idle(5);
    // Uncommitted write strobe is ignored while counting.
    wr(64'd0);
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h55);
    idle(3);
    // Frozen by inhibit, then by mode filter, then reset while a wrap is in flight.
    wr(64'hFFFF_FFFF_FFFF_FFF0); idle(2);
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    for (int k = 0; k < 3; k++) evt(3'd7);
    cycle(1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    cycle(1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    idle(6);
    // Randomized traffic biased toward both half boundaries.
    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 3))
        0: d = {$urandom, $urandom};
        1: d = {32'hFFFF_FFFF, 32'hFFFF_FFE0 | {27'd0, 5'($urandom)}};
        2: d = {$urandom, 32'hFFFF_FFF0 | {28'd0, 4'($urandom)}};
        default: d = {64'hFFFF_FFFF_FFFF_FF00 | {56'd0, 8'($urandom)}};
      endcase
      cycle(k % 700 == 699, $urandom_range(0, 9) < 8, 3'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) != 0, r < 8, $urandom_range(0, 1) == 1, d);
    end
    idle(4);
    @(negedge hpcp_clk);
    #1;
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    checks = checks + 1;
    if (n_ovf < 2) begin
      errors = errors + 1;
      $display("FAIL ovf_coverage got=%0d exp>=2", n_ovf);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
